kernel_stream_ctrl: RTL and testbench
=====================================

KERNEL_STREAM_CTRL -- requirements
Module: kernel_stream_ctrl

Interface
REQ-001 Parameter: C_DATA_WIDTH, default 128; width of input and output stream data.
REQ-002 Parameter: CNTW, default 32; width of item and profiling counters.
REQ-003 Parameter: DRAIN_TO, default 1024; idle cycles allowed in DRAIN before timeout.
REQ-004 Clock and reset: clock aclk; reset areset, synchronous, active-high.
REQ-005 aclk  in  1  clock.
REQ-006 areset  in  1  synchronous active-high reset.
REQ-007 start  in  1  run request, sampled in IDLE only.
REQ-008 num_items  in  CNTW  items for the run, latched on accepted start.
REQ-009 busy  out  1  high in RUN and DRAIN.
REQ-010 done  out  1  one-cycle pulse at end of run.
REQ-011 timeout  out  1  sticky error flag, cleared on next accepted start.
REQ-012 s_tvalid / s_tdata / s_tready  in / in[C_DATA_WIDTH] / out  upstream stream.
REQ-013 k_ivalid / k_idata / k_iready  out / out[C_DATA_WIDTH] / in  kernel input port.
REQ-014 k_ovalid / k_odata / k_oready  in / in[C_DATA_WIDTH] / out  kernel output port.
REQ-015 m_tvalid / m_tdata / m_tready  out / out[C_DATA_WIDTH] / in  downstream stream.
REQ-016 prof_cycles, prof_ivalids, prof_ovalids  out  CNTW each  run profiling counters.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE; the FSM SHALL occupy exactly one state per cycle.
REQ-018 IDLE: start=1 and num_items>0 -> RUN, latch num_items, clear in_cnt, out_cnt, profiling counters, timeout.
REQ-019 IDLE: start=1 and num_items=0 -> DONE directly, counters cleared, no beats transferred.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 k_idata = s_tdata and m_tdata = k_odata combinationally in all states.
REQ-022 RUN: k_ivalid = s_tvalid, s_tready = k_iready; all other states: k_ivalid=0, s_tready=0.
REQ-023 RUN and DRAIN: m_tvalid = k_ovalid, k_oready = m_tready; IDLE and DONE: m_tvalid=0, k_oready=0.
REQ-024 Input beat = k_ivalid & k_iready; in_cnt increments per input beat, never exceeds latched count.
REQ-025 RUN: input beat making in_cnt equal to latched count -> DRAIN next cycle; s_tready=0 from that cycle.
REQ-026 Output beat = k_ovalid & k_oready; out_cnt increments per output beat in RUN and DRAIN.
REQ-027 DRAIN: out_cnt equal to latched count (including the beat this cycle) -> DONE next cycle.
REQ-028 DRAIN: idle counter increments each cycle without output beat, resets on any output beat; reaching DRAIN_TO -> DONE, timeout set.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
REQ-030 prof_cycles increments every RUN/DRAIN cycle; prof_ivalids counts cycles with s_tvalid=1 in RUN; prof_ovalids counts output beats.
REQ-031 Profiling counters hold values from DONE until next accepted start; wrap modulo 2^CNTW.
REQ-032 Simultaneous input and output beat in one cycle SHALL update both counters.
REQ-033 Output beat in the same cycle as transition RUN->DRAIN SHALL be counted.

Reset
REQ-034 areset SHALL force IDLE, busy=0, done=0, timeout=0, all counters 0, s_tready=0, k_ivalid=0, m_tvalid=0, k_oready=0.
REQ-035 areset mid-run SHALL abort immediately with no done pulse; in-flight kernel data is discarded.

Verification
REQ-036 start, num_items=4, kernel latency 3, s_tvalid and m_tready always 1 -> 4 in / 4 out beats, done pulse once, prof_ivalids=4, prof_ovalids=4, timeout=0.
REQ-037 num_items=0 with start -> DONE next cycle, done pulse, s_tready never 1, counters 0.
REQ-038 num_items=3, s_tvalid=1 for 6 cycles -> exactly 3 input beats, s_tready=0 after third beat.
REQ-039 m_tready toggling 1/0 each cycle, num_items=8 -> 8 output beats, done only after 8th, no data lost or duplicated.
REQ-040 DRAIN_TO=16, kernel emits 2 of 4 outputs -> done and timeout=1 16 cycles after last output; next start clears timeout.
REQ-041 areset asserted after 2 of 5 input beats -> next cycle IDLE, busy=0, no done pulse, counters 0.

Source files
------------

// File: rtl/kernel_stream_ctrl.sv
// Run controller that gates an upstream stream into a kernel and the kernel
// result stream downstream, counting items and profiling each run.
module kernel_stream_ctrl #(
  parameter int C_DATA_WIDTH = 128,
  parameter int CNTW         = 32,
  parameter int DRAIN_TO     = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [CNTW-1:0]         num_items,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    s_tready,
  output logic                    k_ivalid,
  output logic [C_DATA_WIDTH-1:0] k_idata,
  input  logic                    k_iready,
  input  logic                    k_ovalid,
  input  logic [C_DATA_WIDTH-1:0] k_odata,
  output logic                    k_oready,
  output logic                    m_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  input  logic                    m_tready,
  output logic [CNTW-1:0]         prof_cycles,
  output logic [CNTW-1:0]         prof_ivalids,
  output logic [CNTW-1:0]         prof_ovalids
);

  localparam int IW = $clog2(DRAIN_TO + 1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(DRAIN_TO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNTW-1:0] n_lat;
  logic [CNTW-1:0] in_cnt;
  logic [CNTW-1:0] out_cnt;
  logic [CNTW-1:0] out_cnt_nx;
  logic [CNTW-1:0] cyc_cnt;
  logic [CNTW-1:0] iv_cnt;
  logic [CNTW-1:0] ov_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            to_r;

  logic in_run;
  logic in_drain;
  logic in_beat;
  logic out_beat;
  logic in_last;
  logic out_last;
  logic idle_hit;
  logic start_ok;
  logic to_set;

  assign k_idata = s_tdata;
  assign m_tdata = k_odata;

  assign in_run   = (state == S_RUN);
  assign in_drain = (state == S_DRAIN);
  assign start_ok = (state == S_IDLE) && start;

  assign in_beat  = in_run && s_tvalid && k_iready;
  assign out_beat = (in_run || in_drain) && k_ovalid && m_tready;

  assign out_cnt_nx = out_cnt + {{(CNTW-1){1'b0}}, out_beat};

  assign in_last  = in_beat && ((in_cnt + CNTW'(1)) == n_lat);
  assign out_last = (out_cnt_nx == n_lat);
  assign idle_hit = !out_beat && ((idle_cnt + IW'(1)) == IDLE_LIM);
  assign to_set   = in_drain && !out_last && idle_hit;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    s_tready = 1'b0;
    k_ivalid = 1'b0;
    m_tvalid = 1'b0;
    k_oready = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (num_items == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        k_ivalid = s_tvalid;
        s_tready = k_iready;
        m_tvalid = k_ovalid;
        k_oready = m_tready;
        if (in_last) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy     = 1'b1;
        m_tvalid = k_ovalid;
        k_oready = m_tready;
        if (out_last || idle_hit) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Profiling and item counters freeze outside RUN/DRAIN until the next start
  always_ff @(posedge aclk) begin
    if (areset) begin
      n_lat    <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      cyc_cnt  <= '0;
      iv_cnt   <= '0;
      ov_cnt   <= '0;
      idle_cnt <= '0;
      to_r     <= 1'b0;
    end else if (start_ok) begin
      n_lat    <= num_items;
      in_cnt   <= '0;
      out_cnt  <= '0;
      cyc_cnt  <= '0;
      iv_cnt   <= '0;
      ov_cnt   <= '0;
      idle_cnt <= '0;
      to_r     <= 1'b0;
    end else begin
      if (in_beat) begin
        in_cnt <= in_cnt + CNTW'(1);
      end
      if (out_beat) begin
        out_cnt <= out_cnt_nx;
        ov_cnt  <= ov_cnt + CNTW'(1);
      end
      if (in_run || in_drain) begin
        cyc_cnt <= cyc_cnt + CNTW'(1);
      end
      if (in_run && s_tvalid) begin
        iv_cnt <= iv_cnt + CNTW'(1);
      end
      if (in_drain && !out_beat) begin
        idle_cnt <= idle_cnt + IW'(1);
      end else begin
        idle_cnt <= '0;
      end
      if (to_set) begin
        to_r <= 1'b1;
      end
    end
  end

  assign timeout      = to_r;
  assign prof_cycles  = cyc_cnt;
  assign prof_ivalids = iv_cnt;
  assign prof_ovalids = ov_cnt;

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Randomised scoreboard bench for kernel_stream_ctrl with a latency-3
// kernel model and per-run timing/profiling predictions.
module tb_kernel_stream_ctrl;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int DTO = 16;
  localparam int LAT = 3;

  logic          aclk;
  logic          areset;
  logic          start;
  logic [CW-1:0] num_items;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tready;
  logic          k_ivalid;
  logic [DW-1:0] k_idata;
  logic          k_iready;
  logic          k_ovalid;
  logic [DW-1:0] k_odata;
  logic          k_oready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tready;
  logic [CW-1:0] prof_cycles;
  logic [CW-1:0] prof_ivalids;
  logic [CW-1:0] prof_ovalids;

  kernel_stream_ctrl #(
    .C_DATA_WIDTH(DW),
    .CNTW(CW),
    .DRAIN_TO(DTO)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .start(start),
    .num_items(num_items),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .s_tvalid(s_tvalid),
    .s_tdata(s_tdata),
    .s_tready(s_tready),
    .k_ivalid(k_ivalid),
    .k_idata(k_idata),
    .k_iready(k_iready),
    .k_ovalid(k_ovalid),
    .k_odata(k_odata),
    .k_oready(k_oready),
    .m_tvalid(m_tvalid),
    .m_tdata(m_tdata),
    .m_tready(m_tready),
    .prof_cycles(prof_cycles),
    .prof_ivalids(prof_ivalids),
    .prof_ovalids(prof_ovalids)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } kent_t;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  kent_t         kq[$];

  int mmode     = 0;
  bit src_rand  = 0;
  bit krdy_rand = 0;
  int klim      = 1000;
  int kacc      = 0;
  bit exp_to_r  = 0;
  int done_cnt  = 0;
  int ib        = 0;

  function automatic logic [DW-1:0] kfn(input logic [DW-1:0] d);
    return d ^ 32'hC3A5_5A3C;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string nm, input longint a, input longint e);
    checks++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Source, kernel and sink bus models
  initial begin
    bit            s_hs;
    bit            k_in;
    bit            k_out;
    bit            rst_s;
    logic [DW-1:0] kin_d;
    int            bcyc;
    bcyc     = 0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    k_iready = 1'b0;
    k_ovalid = 1'b0;
    k_odata  = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge aclk);
      s_hs  = s_tvalid && s_tready;
      k_in  = k_ivalid && k_iready;
      kin_d = k_idata;
      k_out = k_ovalid && k_oready;
      rst_s = areset;
      @(posedge aclk);
      #1;
      bcyc++;
      if (k_out && kq.size() > 0) void'(kq.pop_front());
      if (k_in) begin
        if (kacc < klim) kq.push_back('{kfn(kin_d), bcyc + LAT - 1});
        kacc++;
      end
      if (rst_s) kq.delete();
      if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
      k_ovalid = (kq.size() > 0) && (kq[0].t <= bcyc);
      k_odata  = (kq.size() > 0) ? kq[0].d : '0;
      k_iready = (kq.size() < 8) && (!krdy_rand || $urandom_range(0, 3) != 0);
      s_tvalid = (src_q.size() > 0) && (!src_rand || $urandom_range(0, 2) != 0);
      s_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
      case (mmode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pops and per-run predictions
  initial begin
    int cyc;
    int n_run;
    int ob;
    int iv;
    int bz;
    int c_acc;
    int t_in;
    int l_out;
    int exp_d;
    bit idle_m;
    bit run_ph;
    bit post_acc;
    bit post_rst;
    logic [DW-1:0] e;
    cyc = 0; n_run = 0; ob = 0; iv = 0; bz = 0;
    c_acc = 0; t_in = 0; l_out = 0;
    idle_m = 1; run_ph = 0; post_acc = 0; post_rst = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (post_rst) begin
        post_rst = 0;
        chk("rst_prof_cycles", prof_cycles, 0);
        chk("rst_prof_ivalids", prof_ivalids, 0);
        chk("rst_prof_ovalids", prof_ovalids, 0);
        chk("rst_flags", {done, timeout, m_tvalid, k_oready}, 0);
      end
      if (post_acc) begin
        post_acc = 0;
        chk("timeout_cleared", timeout, 0);
      end
      if (idle_m) chk("busy_idle", busy, 0);
      else if (busy) bz++;
      if (k_ivalid) chk("k_idata_pass", k_idata, s_tdata);
      if (m_tvalid) chk("m_tdata_pass", m_tdata, k_odata);
      if (s_tready) begin
        checks++;
        if (!run_ph) begin
          fails++;
          $display("FAIL s_tready_gate: got 1 expected 0 at cycle %0d", cyc);
        end
      end
      if (run_ph && s_tvalid) iv++;
      if (s_tvalid && s_tready) begin
        ib++;
        if (ib == n_run) begin
          run_ph = 0;
          t_in = cyc;
        end
      end
      if (m_tvalid && m_tready) begin
        ob++;
        l_out = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL out_unexpected: got %0h expected none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e);
        end
      end
      if (start && idle_m && !areset) begin
        n_run = int'(num_items);
        ib = 0; ob = 0; iv = 0; bz = 0;
        c_acc = cyc; t_in = cyc; l_out = cyc;
        idle_m = 0;
        run_ph = (n_run > 0);
        post_acc = 1;
      end else if (done) begin
        if (idle_m) begin
          checks++;
          fails++;
          $display("FAIL done_unexpected: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          if (n_run == 0) exp_d = c_acc + 1;
          else if (exp_to_r) exp_d = imax(t_in, l_out) + DTO + 1;
          else exp_d = imax(t_in + 2, l_out + 1);
          chk("done_cycle", cyc, exp_d);
          chk("busy_in_done", busy, 0);
          chk("busy_cycles", bz, cyc - c_acc - 1);
          chk("prof_cycles", prof_cycles, cyc - c_acc - 1);
          chk("prof_ivalids", prof_ivalids, iv);
          chk("prof_ovalids", prof_ovalids, ob);
          chk("timeout_flag", timeout, exp_to_r);
          chk("in_beats", ib, n_run);
          chk("exp_q_drained", exp_q.size(), 0);
        end
        idle_m = 1;
        run_ph = 0;
        done_cnt++;
      end
      if (areset) begin
        idle_m = 1;
        run_ph = 0;
        post_acc = 0;
        post_rst = 1;
      end
    end
  end

  task automatic launch(input int n, input int offer, input int lim, input bit to);
    logic [DW-1:0] d;
    for (int i = 0; i < offer; i++) begin
      d = $urandom;
      src_q.push_back(d);
      if (i < n && i < lim) exp_q.push_back(kfn(d));
    end
    kacc      = 0;
    klim      = lim;
    exp_to_r  = to;
    num_items = CW'(n);
    start     = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (done_cnt != d0) break;
      @(posedge aclk);
      #1;
    end
    if (done_cnt == d0) begin
      checks++;
      fails++;
      $display("FAIL done_wait: got no done expected done within 3000 cycles");
    end
    @(posedge aclk);
    #1;
    src_q.delete();
  endtask

  task automatic run(input int n, input int offer, input int lim, input bit to);
    int d0;
    d0 = done_cnt;
    launch(n, offer, lim, to);
    wait_done(d0);
    chk("done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    int k;
    areset    = 1'b1;
    start     = 1'b0;
    num_items = '0;
    src_q.push_back(32'h1111_2222);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_gates", {s_tready, k_ivalid, m_tvalid, k_oready}, 0);
    chk("reset_prof", {prof_cycles, prof_ivalids, prof_ovalids}, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    src_q.delete();
    repeat (2) @(posedge aclk);
    #1;

    run(4, 4, 1000, 0);
    chk("r4_ivalids", prof_ivalids, 4);
    chk("r4_ovalids", prof_ovalids, 4);
    chk("r4_timeout", timeout, 0);

    run(0, 2, 1000, 0);
    chk("r0_prof", {prof_cycles, prof_ivalids, prof_ovalids}, 0);

    run(3, 6, 1000, 0);
    chk("r3_ivalids", prof_ivalids, 3);

    mmode = 1;
    run(8, 8, 1000, 0);
    chk("r8_ovalids", prof_ovalids, 8);
    mmode = 0;

    run(4, 4, 2, 1);
    chk("to_sticky_idle", timeout, 1);
    chk("to_ovalids", prof_ovalids, 2);

    d0 = done_cnt;
    launch(5, 5, 1000, 0);
    repeat (3) @(posedge aclk);
    #1;
    num_items = CW'(2);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    wait_done(d0);
    chk("ignored_start_items", prof_ovalids, 5);

    for (int r = 0; r < 16; r++) begin
      int n;
      n = $urandom_range(1, 12);
      mmode = $urandom_range(0, 2);
      src_rand = $urandom_range(0, 1);
      krdy_rand = $urandom_range(0, 1);
      run(n, n + $urandom_range(0, 3), 1000, 0);
    end
    mmode = 0;
    src_rand = 0;
    krdy_rand = 0;

    d0 = done_cnt;
    launch(5, 5, 1000, 0);
    for (k = 0; k < 200; k++) begin
      if (ib >= 2) break;
      @(posedge aclk);
      #1;
    end
    chk("rst_mid_beats_seen", ib >= 2, 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (6) @(posedge aclk);
    #1;
    chk("rst_no_done", done_cnt, d0);
    chk("rst_idle_busy", busy, 0);

    run(6, 6, 1000, 0);
    chk("post_rst_ovalids", prof_ovalids, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule
